// File: rtl/demux_1_8_deser_if.sv
// Bus interface for the 1-to-8 serial demux/deserializer.
// With DEMUX_DESER_PARITY_EN defined, o_par_err is added to the bus.
interface demux_1_8_deser_if #(
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    logic             i_en;
    logic             i_valid;
    logic             i_f;
    logic [SEL_W-1:0] i_sel_code;
    logic             i_auto;
    logic             i_clr;
    logic [N-1:0]     o_code;
    logic [N-1:0]     o_frame;
    logic             o_frame_valid;
    logic [SEL_W-1:0] o_ptr;
`ifdef DEMUX_DESER_PARITY_EN
    logic             o_par_err;
`endif

    modport master (
        output i_en, i_valid, i_f, i_sel_code, i_auto, i_clr,
`ifdef DEMUX_DESER_PARITY_EN
        input  o_par_err,
`endif
        input  o_code, o_frame, o_frame_valid, o_ptr
    );

    modport slave (
        input  i_en, i_valid, i_f, i_sel_code, i_auto, i_clr,
`ifdef DEMUX_DESER_PARITY_EN
        output o_par_err,
`endif
        output o_code, o_frame, o_frame_valid, o_ptr
    );
endinterface

// File: rtl/demux_1_8_deser.sv
// Sequential 1-to-N demux / deserializer: addressed or auto-pointer bit writes,
// auto mode publishes full frames. DEMUX_DESER_PARITY_EN adds an even-parity beat.
module demux_1_8_deser #(
    parameter int SEL_W    = 3,
    parameter int AUTO_DIR = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    demux_1_8_deser_if.slave      io_bus
);
    localparam int N = 1 << SEL_W;
    localparam logic [SEL_W-1:0] PTR_START = (AUTO_DIR != 0) ? {SEL_W{1'b1}} : '0;
    localparam logic [SEL_W-1:0] PTR_LAST  = (AUTO_DIR != 0) ? '0 : {SEL_W{1'b1}};

    logic [N-1:0]     r_code;
    logic [N-1:0]     r_frame;
    logic             r_frame_valid;
    logic [SEL_W-1:0] r_ptr;
    logic [N-1:0]     w_code_nxt;
    logic [SEL_W-1:0] w_ptr_step;
    logic             w_wr;
    logic             w_auto_data;

`ifdef DEMUX_DESER_PARITY_EN
    localparam logic [0:0] ST_DATA   = 1'b0;
    localparam logic [0:0] ST_PARITY = 1'b1;
    logic [0:0] r_state;
    logic       r_par_err;
    assign w_auto_data = (r_state == ST_DATA);
    assign io_bus.o_par_err = r_par_err;
`else
    assign w_auto_data = 1'b1;
`endif

    assign w_wr       = io_bus.i_en & io_bus.i_valid;
    assign w_ptr_step = (AUTO_DIR != 0) ? r_ptr - SEL_W'(1) : r_ptr + SEL_W'(1);

    // Working register with this cycle's bit merged in; frame capture uses it too.
    always_comb begin
        w_code_nxt = r_code;
        if (w_wr && !io_bus.i_auto)
            w_code_nxt[io_bus.i_sel_code] = io_bus.i_f;
        else if (w_wr && io_bus.i_auto && w_auto_data)
            w_code_nxt[r_ptr] = io_bus.i_f;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_code        <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_ptr         <= PTR_START;
`ifdef DEMUX_DESER_PARITY_EN
            r_state       <= ST_DATA;
            r_par_err     <= 1'b0;
`endif
        end else begin
            r_frame_valid <= 1'b0;
`ifdef DEMUX_DESER_PARITY_EN
            r_par_err     <= 1'b0;
`endif
            if (io_bus.i_clr) begin
                r_code  <= '0;
                r_ptr   <= PTR_START;
`ifdef DEMUX_DESER_PARITY_EN
                r_state <= ST_DATA;
`endif
            end else if (w_wr) begin
                r_code <= w_code_nxt;
                if (io_bus.i_auto) begin
`ifdef DEMUX_DESER_PARITY_EN
                    // Pointer parks on the last position while the parity beat is pending.
                    if (r_state == ST_PARITY) begin
                        r_frame       <= r_code;
                        r_frame_valid <= 1'b1;
                        r_par_err     <= (^r_code) != io_bus.i_f;
                        r_ptr         <= PTR_START;
                        r_state       <= ST_DATA;
                    end else if (r_ptr == PTR_LAST) begin
                        r_state <= ST_PARITY;
                    end else begin
                        r_ptr <= w_ptr_step;
                    end
`else
                    if (r_ptr == PTR_LAST) begin
                        r_frame       <= w_code_nxt;
                        r_frame_valid <= 1'b1;
                        r_ptr         <= PTR_START;
                    end else begin
                        r_ptr <= w_ptr_step;
                    end
`endif
                end
            end
        end
    end

    assign io_bus.o_code        = r_code;
    assign io_bus.o_frame       = r_frame;
    assign io_bus.o_frame_valid = r_frame_valid;
    assign io_bus.o_ptr         = r_ptr;
endmodule
